// File: rtl/arbiter_pkg.sv
// Shared types for the request/acknowledge arbiters.
// Policy and FSM encodings live here so every arbiter agrees on them.
package arbiter_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection: fixed priority or rotating start.
// Scans from ptr upward with wrap; fixed mode always scans from 0.
module arb_pick
  import arbiter_pkg::*;
#(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  input  arb_mode_t    mode,
  output logic [N-1:0] oh,
  output logic [W-1:0] idx,
  output logic         any
);

  int start;
  int j;

  // first active request at or after the scan start
  always_comb begin
    oh    = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    start = (mode == ARB_RR) ? int'(ptr) : 0;
    for (int i = 0; i < N; i++) begin
      j = start + i;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any   = 1'b1;
        oh[j] = 1'b1;
        idx   = W'(j);
      end
    end
  end

endmodule

// File: rtl/arbiter_sync_rr.sv
// Request/acknowledge arbiter: picks one requester and relays its
// handshake to the next block. All outputs come straight from flops.
module arbiter_sync_rr
  import arbiter_pkg::*;
#(
  parameter int        N    = 8,
  parameter arb_mode_t MODE = ARB_RR
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_in,
  output logic [N-1:0]         ack_in,
  output logic                 req_out,
  input  logic                 ack_out,
  output logic [N-1:0]         sel,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 busy
);

  localparam int W = $clog2(N);

  arb_state_t   state_q;
  arb_state_t   state_d;
  logic [W-1:0] ptr_q;
  logic [W-1:0] ptr_d;
  logic [W-1:0] ptr_nxt;
  logic [N-1:0] sel_d;
  logic [W-1:0] gid_d;
  logic [N-1:0] ack_d;
  logic         ro_d;
  logic         busy_d;

  logic [N-1:0] pick_oh;
  logic [W-1:0] pick_idx;
  logic         pick_any;

  arb_pick #(
    .N (N),
    .W (W)
  ) u_pick (
    .req  (req_in),
    .ptr  (ptr_q),
    .mode (MODE),
    .oh   (pick_oh),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  assign ptr_nxt = (grant_id == W'(N - 1)) ? '0
                 : grant_id + W'(1);

  // next-state and registered-output values
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel;
    gid_d   = grant_id;
    ack_d   = ack_in;
    ro_d    = req_out;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          sel_d   = pick_oh;
          gid_d   = pick_idx;
          ro_d    = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (ack_out) begin
          ro_d    = 1'b0;
          ack_d   = sel;
          state_d = ACK;
        end
      end
      ACK: begin
        if (!req_in[grant_id] && !ack_out) begin
          ack_d   = '0;
          sel_d   = '0;
          gid_d   = '0;
          state_d = IDLE;
          if (MODE == ARB_RR) ptr_d = ptr_nxt;
        end
      end
      default: begin
        ack_d   = '0;
        sel_d   = '0;
        gid_d   = '0;
        ro_d    = 1'b0;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // state and output registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      sel      <= '0;
      grant_id <= '0;
      ack_in   <= '0;
      req_out  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      sel      <= sel_d;
      grant_id <= gid_d;
      ack_in   <= ack_d;
      req_out  <= ro_d;
      busy     <= busy_d;
    end
  end

endmodule

// File: tb/tb_arbiter_sync_rr.sv
// Scoreboard bench for arbiter_sync_rr: one round-robin and one
// fixed-priority instance, expected grants queued at issue time.
module tb_arbiter_sync_rr;
  import arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req_r, req_f;
  logic       ack_out_r, ack_out_f;
  logic [7:0] ack_in_r, ack_in_f;
  logic [7:0] sel_r, sel_f;
  logic [2:0] gid_r, gid_f;
  logic       req_out_r, req_out_f;
  logic       busy_r, busy_f;

  int tests = 0;
  int fails = 0;

  logic [10:0] qg_r[$];
  logic [10:0] qg_f[$];
  logic [7:0]  qa_r[$];
  logic [7:0]  qa_f[$];

  logic       pro  [2] = '{1'b0, 1'b0};
  logic [7:0] pack [2] = '{8'h00, 8'h00};

  always #5 clk = ~clk;

  arbiter_sync_rr #(.N(8), .MODE(ARB_RR)) u_rr (
    .clk      (clk),
    .rst      (rst),
    .req_in   (req_r),
    .ack_in   (ack_in_r),
    .req_out  (req_out_r),
    .ack_out  (ack_out_r),
    .sel      (sel_r),
    .grant_id (gid_r),
    .busy     (busy_r)
  );

  arbiter_sync_rr #(.N(8), .MODE(ARB_FIXED)) u_fx (
    .clk      (clk),
    .rst      (rst),
    .req_in   (req_f),
    .ack_in   (ack_in_f),
    .req_out  (req_out_f),
    .ack_out  (ack_out_f),
    .sel      (sel_f),
    .grant_id (gid_f),
    .busy     (busy_f)
  );

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic observe(input int d, input logic ro,
                         input logic [7:0] s, input logic [2:0] g,
                         input logic [7:0] a);
    logic [10:0] e;
    logic [7:0]  ea;
    tests++;
    if ($countones(s) > 1 || $countones(a) > 1 || (ro && a != 0)) begin
      fails++;
      $display("FAIL invariant dut%0d: sel=%h ack_in=%h req_out=%b",
               d, s, a, ro);
    end
    if (ro && !pro[d]) begin
      if ((d == 0 ? qg_r.size() : qg_f.size()) == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_grant dut%0d: sel=%h", d, s);
      end else begin
        e = (d == 0) ? qg_r.pop_front() : qg_f.pop_front();
        check($sformatf("grant dut%0d", d), {21'd0, g, s}, {21'd0, e});
      end
    end
    if (a != 0 && pack[d] == 0) begin
      if ((d == 0 ? qa_r.size() : qa_f.size()) == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_ack dut%0d: ack_in=%h", d, a);
      end else begin
        ea = (d == 0) ? qa_r.pop_front() : qa_f.pop_front();
        check($sformatf("ack_in dut%0d", d), {24'd0, a}, {24'd0, ea});
      end
    end
    pro[d]  = ro;
    pack[d] = a;
  endtask

  always @(negedge clk) begin
    observe(0, req_out_r, sel_r, gid_r, ack_in_r);
    observe(1, req_out_f, sel_f, gid_f, ack_in_f);
  end

  function automatic logic cond(input bit fx, input int what);
    case (what)
      0:       return fx ? req_out_f : req_out_r;
      1:       return fx ? (ack_in_f != 0) : (ack_in_r != 0);
      default: return fx ? !busy_f : !busy_r;
    endcase
  endfunction

  task automatic wait_for(input bit fx, input int what,
                          input string name);
    bit hit = 1'b0;
    for (int i = 0; i < 12 && !hit; i++) begin
      @(posedge clk);
      #1;
      hit = cond(fx, what);
    end
    tests++;
    if (!hit) begin
      fails++;
      $display("FAIL timeout %s dut%0d: got none expected event",
               name, fx);
    end
  endtask

  task automatic set_req(input bit fx, input logic [7:0] v);
    if (fx) req_f = v;
    else    req_r = v;
  endtask

  task automatic set_ack(input bit fx, input logic v);
    if (fx) ack_out_f = v;
    else    ack_out_r = v;
  endtask

  task automatic expect_grant(input bit fx, input int g);
    logic [7:0] oh;
    oh = 8'b1 << g;
    if (fx) begin
      qg_f.push_back({3'(g), oh});
      qa_f.push_back(oh);
    end else begin
      qg_r.push_back({3'(g), oh});
      qa_r.push_back(oh);
    end
  endtask

  task automatic check_idle(input bit fx, input string name);
    if (fx) check(name, {sel_f, gid_f, ack_in_f, req_out_f, busy_f}, 0);
    else    check(name, {sel_r, gid_r, ack_in_r, req_out_r, busy_r}, 0);
  endtask

  task automatic txn(input bit fx, input logic [7:0] r,
                     input int g, input int dly);
    logic [7:0] oh;
    oh = 8'b1 << g;
    expect_grant(fx, g);
    set_req(fx, r);
    wait_for(fx, 0, "req_out");
    repeat (dly) begin
      @(posedge clk);
      #1;
    end
    set_ack(fx, 1'b1);
    wait_for(fx, 1, "ack_in");
    set_req(fx, r & ~oh);
    set_ack(fx, 1'b0);
    wait_for(fx, 2, "idle");
    check_idle(fx, "idle_outputs");
    set_req(fx, 8'h00);
  endtask

  function automatic int pick_rr(input logic [7:0] r, input int p);
    for (int i = 0; i < 8; i++) begin
      if (r[(p + i) % 8]) return (p + i) % 8;
    end
    return 0;
  endfunction

  initial begin
    int ptr_m;
    int g;
    logic [7:0] r;
    rst       = 1'b0;
    req_r     = 8'hFF;
    req_f     = 8'hFF;
    ack_out_r = 1'b0;
    ack_out_f = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle(0, "reset_rr");
    check_idle(1, "reset_fixed");
    req_r = 8'h00;
    req_f = 8'h00;
    rst   = 1'b1;
    @(posedge clk);
    #1;

    for (int k = 0; k < 9; k++) txn(0, 8'hFF, k % 8, 0);
    for (int k = 0; k < 9; k++) txn(1, 8'hFF, 0, 0);
    txn(1, 8'h41, 0, 0);
    txn(1, 8'h40, 6, 0);

    txn(0, 8'h10, 4, 1);
    txn(0, 8'h40, 6, 0);
    txn(0, 8'h41, 0, 0);

    expect_grant(0, 2);
    req_r = 8'h04;
    wait_for(0, 0, "req_out");
    req_r = 8'h0B;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("stable_req", {gid_r, sel_r}, {3'd2, 8'h04});
    end
    ack_out_r = 1'b1;
    wait_for(0, 1, "ack_in");
    check("stable_ack", {gid_r, sel_r}, {3'd2, 8'h04});
    expect_grant(0, 3);
    ack_out_r = 1'b0;
    wait_for(0, 2, "idle");
    check_idle(0, "stable_release");
    wait_for(0, 0, "req_out");
    ack_out_r = 1'b1;
    wait_for(0, 1, "ack_in");
    req_r     = 8'h00;
    ack_out_r = 1'b0;
    wait_for(0, 2, "idle");

    expect_grant(0, 3);
    req_r = 8'h08;
    wait_for(0, 0, "req_out");
    ack_out_r = 1'b1;
    wait_for(0, 1, "ack_in");
    rst       = 1'b0;
    req_r     = 8'h00;
    ack_out_r = 1'b0;
    @(posedge clk);
    #1;
    check_idle(0, "mid_reset");
    rst = 1'b1;
    txn(0, 8'hFF, 0, 0);

    ptr_m = 1;
    for (int k = 0; k < 1000; k++) begin
      r = 8'($urandom_range(1, 255));
      g = pick_rr(r, ptr_m);
      txn(0, r, g, $urandom_range(0, 2));
      ptr_m = (g + 1) % 8;
    end

    repeat (2) @(posedge clk);
    #1;
    check("queues_empty",
          qg_r.size() + qg_f.size() + qa_r.size() + qa_f.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
